// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control sequencer: modes, opcodes,
// ALU commands, FSM states and default sizing.
`timescale 1ns/1ps
package ctrl_pkg;

    localparam int DEF_NUM_REGS   = 16;
    localparam int DEF_EXE_CMD_W  = 4;
    localparam int DEF_WORD_BYTES = 4;

    localparam logic [1:0] MODE_DP    = 2'b00;
    localparam logic [1:0] MODE_MEM   = 2'b01;
    localparam logic [1:0] MODE_BR    = 2'b10;
    localparam logic [1:0] MODE_BLOCK = 2'b11;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BLOCK
    } state_e;

endpackage

// File: rtl/control_decode.sv
// Combinational single-op decode of {mode, op_code, s_in} into EXE/MEM/WB
// control. Block transfers decode like a single load/store.
`timescale 1ns/1ps
module control_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [3:0] op_code_i,
    input  logic       s_in_i,
    output logic [3:0] exe_cmd_o,
    output logic       s_o,
    output logic       b_o,
    output logic       mem_w_en_o,
    output logic       mem_r_en_o,
    output logic       wb_en_o,
    output logic       illegal_o
);

    always_comb begin
        exe_cmd_o  = EXE_NOP;
        s_o        = 1'b0;
        b_o        = 1'b0;
        mem_w_en_o = 1'b0;
        mem_r_en_o = 1'b0;
        wb_en_o    = 1'b0;
        illegal_o  = 1'b0;
        case (mode_i)
            MODE_DP: begin
                s_o     = s_in_i;
                wb_en_o = 1'b1;
                case (op_code_i)
                    OP_MOV:  exe_cmd_o = EXE_MOV;
                    OP_MVN:  exe_cmd_o = EXE_MVN;
                    OP_ADD:  exe_cmd_o = EXE_ADD;
                    OP_ADC:  exe_cmd_o = EXE_ADC;
                    OP_SUB:  exe_cmd_o = EXE_SUB;
                    OP_SBC:  exe_cmd_o = EXE_SBC;
                    OP_AND:  exe_cmd_o = EXE_AND;
                    OP_ORR:  exe_cmd_o = EXE_ORR;
                    OP_EOR:  exe_cmd_o = EXE_EOR;
                    OP_CMP: begin
                        exe_cmd_o = EXE_SUB;
                        wb_en_o   = 1'b0;
                    end
                    OP_TST: begin
                        exe_cmd_o = EXE_AND;
                        wb_en_o   = 1'b0;
                    end
                    default: begin
                        wb_en_o   = 1'b0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            MODE_MEM, MODE_BLOCK: begin
                s_o        = s_in_i;
                exe_cmd_o  = EXE_ADD;
                mem_w_en_o = !s_in_i;
                mem_r_en_o = s_in_i;
                wb_en_o    = s_in_i;
            end
            MODE_BR: b_o = 1'b1;
            default: exe_cmd_o = EXE_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Registered, handshaked ID-stage control unit; expands LDM/STM register
// lists into one micro-op per set bit while holding off the front end.
`timescale 1ns/1ps
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int EXE_CMD_W  = DEF_EXE_CMD_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    localparam int REG_W     = $clog2(NUM_REGS),
    localparam int OFF_W     = REG_W + $clog2(WORD_BYTES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0]           op_code_i,
    input  logic [1:0]           mode_i,
    input  logic                 s_in_i,
    input  logic [NUM_REGS-1:0]  reg_list_i,
    input  logic                 flush_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic                 s_o,
    output logic                 b_o,
    output logic                 mem_w_en_o,
    output logic                 mem_r_en_o,
    output logic                 wb_en_o,
    output logic [EXE_CMD_W-1:0] exe_cmd_o,
    output logic [REG_W-1:0]     uop_reg_o,
    output logic [OFF_W-1:0]     uop_offset_o,
    output logic                 uop_last_o,
    output logic                 illegal_o
);

    state_e               state_q;
    logic [NUM_REGS-1:0]  rem_q;
    logic [REG_W-1:0]     k_q;
    logic                 out_valid_q, s_q, b_q, mem_w_q, mem_r_q, wb_q, last_q, ill_q;
    logic [EXE_CMD_W-1:0] exe_q;
    logic [REG_W-1:0]     reg_q;
    logic [OFF_W-1:0]     off_q;

    logic [3:0]           dec_exe;
    logic                 dec_s, dec_b, dec_mw, dec_mr, dec_wb, dec_ill;
    logic                 accept, retire, is_block, list_empty;
    logic [NUM_REGS-1:0]  scan_list, rem_d;
    logic [REG_W-1:0]     next_reg_d, next_k_d;

    control_decode u_decode (
        .mode_i     (mode_i),
        .op_code_i  (op_code_i),
        .s_in_i     (s_in_i),
        .exe_cmd_o  (dec_exe),
        .s_o        (dec_s),
        .b_o        (dec_b),
        .mem_w_en_o (dec_mw),
        .mem_r_en_o (dec_mr),
        .wb_en_o    (dec_wb),
        .illegal_o  (dec_ill)
    );

    assign in_ready_o = (state_q == ST_IDLE || (state_q == ST_ISSUE && out_ready_i)) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign retire     = out_valid_q && out_ready_i;
    assign is_block   = (mode_i == MODE_BLOCK);

    // Accepts never happen in BLOCK, so one encoder serves both the incoming
    // list and the captured remainder.
    assign scan_list  = (state_q == ST_BLOCK) ? rem_q : reg_list_i;
    assign list_empty = (scan_list == '0);
    assign rem_d      = scan_list & (scan_list - 1'b1);
    assign next_k_d   = k_q + 1'b1;

    always_comb begin
        next_reg_d = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (scan_list[i]) next_reg_d = REG_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            b_q         <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_r_q     <= 1'b0;
            wb_q        <= 1'b0;
            exe_q       <= '0;
            reg_q       <= '0;
            off_q       <= '0;
            last_q      <= 1'b0;
            ill_q       <= 1'b0;
        end else if (flush_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            s_q         <= dec_s;
            b_q         <= dec_b;
            exe_q       <= EXE_CMD_W'(dec_exe);
            ill_q       <= dec_ill;
            k_q         <= '0;
            off_q       <= '0;
            // An empty list still issues one op so the instruction retires, but it does nothing.
            mem_w_q     <= dec_mw && !(is_block && list_empty);
            mem_r_q     <= dec_mr && !(is_block && list_empty);
            wb_q        <= dec_wb && !(is_block && list_empty);
            reg_q       <= is_block ? next_reg_d : '0;
            rem_q       <= is_block ? rem_d : '0;
            last_q      <= !is_block || (rem_d == '0);
            state_q     <= (is_block && rem_d != '0) ? ST_BLOCK : ST_ISSUE;
        end else if (state_q == ST_BLOCK) begin
            if (retire) begin
                reg_q   <= next_reg_d;
                k_q     <= next_k_d;
                off_q   <= OFF_W'(next_k_d * WORD_BYTES);
                rem_q   <= rem_d;
                last_q  <= (rem_d == '0);
                if (rem_d == '0) state_q <= ST_ISSUE;
            end
        end else if (retire) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign s_o          = s_q;
    assign b_o          = b_q;
    assign mem_w_en_o   = mem_w_q;
    assign mem_r_en_o   = mem_r_q;
    assign wb_en_o      = wb_q;
    assign exe_cmd_o    = exe_q;
    assign uop_reg_o    = reg_q;
    assign uop_offset_o = off_q;
    assign uop_last_o   = last_q;
    assign illegal_o    = ill_q;

endmodule
